gcd_job_master: RTL and testbench

//  Initiator side of the GCD start/done interface. Accepts operand pairs on a valid/ready

---
 rtl/gcd_pkg.sv | 10 +
 rtl/gcd_job_master.sv | 85 ++++++++
 tb/tb_gcd_job_master.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM state encoding and default data width for the GCD master and calculator
package gcd_pkg;
  localparam int GCD_DATA_W = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/gcd_job_master.sv
// gcd_job_master: valid/ready front end driving one GCD calculator, with zero bypass, watchdog and statistics
module gcd_job_master #(
  parameter int DATA_W      = gcd_pkg::GCD_DATA_W,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_gcd,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              calc_start,
  output logic [DATA_W-1:0] calc_a,
  output logic [DATA_W-1:0] calc_b,
  input  logic              calc_done,
  input  logic [DATA_W-1:0] calc_gcd,
  output logic [15:0]       jobs_done,
  output logic [7:0]        timeouts
);
  import gcd_pkg::*;
  localparam int TW = $clog2(TIMEOUT_CYC);
  state_t state, nxt;
  logic [TW-1:0] timer;
  logic zero_op, expired;
  assign zero_op    = req_a == '0 || req_b == '0;
  assign expired    = timer == TW'(TIMEOUT_CYC - 1);
  assign req_ready  = rst_n && state == IDLE;
  assign rsp_valid  = state == RESP;
  assign calc_start = state == ISSUE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_valid ? (zero_op ? RESP : ISSUE) : IDLE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = (calc_done || expired) ? RESP : WAIT;
      RESP:    nxt = rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      calc_a    <= '0;
      calc_b    <= '0;
      rsp_tag   <= '0;
      rsp_gcd   <= '0;
      rsp_err   <= 1'b0;
      jobs_done <= '0;
      timeouts  <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (req_valid) begin
          calc_a  <= req_a;
          calc_b  <= req_b;
          rsp_tag <= req_tag;
          rsp_gcd <= req_a | req_b;
          rsp_err <= 1'b0;
        end
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + TW'(1);
          if (calc_done) begin
            rsp_gcd <= calc_gcd;
            rsp_err <= 1'b0;
          end else if (expired) begin
            rsp_gcd  <= '0;
            rsp_err  <= 1'b1;
            timeouts <= timeouts + {7'd0, timeouts != 8'hFF};
          end
        end
        RESP: if (rsp_ready) jobs_done <= jobs_done + 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_job_master.sv
// tb_gcd_job_master: scoreboard bench with a behavioural calculator and Euclid reference model
module tb_gcd_job_master;
  localparam int DW = 8, TGW = 4, TO = 64;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready, rsp_err, calc_start, calc_done;
  logic [DW-1:0] req_a = 0, req_b = 0, rsp_gcd, calc_a, calc_b, calc_gcd;
  logic [TGW-1:0] req_tag = 0, rsp_tag;
  logic [15:0] jobs_done;
  logic [7:0] timeouts;
  always #5 clk = ~clk;
  gcd_job_master #(.DATA_W(DW), .TAG_W(TGW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_gcd(rsp_gcd), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .calc_start(calc_start), .calc_a(calc_a), .calc_b(calc_b), .calc_done(calc_done),
    .calc_gcd(calc_gcd), .jobs_done(jobs_done), .timeouts(timeouts)
  );
  typedef struct packed {logic [DW-1:0] g; logic [TGW-1:0] t; logic e;} exp_t;
  exp_t q[$];
  int pass_cnt = 0, total = 0, starts = 0, exp_jobs = 0, exp_to = 0;
  int job_lat = 5, rdy_mode = 1;
  bit job_never = 0, stray = 0;
  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  task automatic check(input string nm, input longint act, input longint req);
    total++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask
  initial begin
    bit busy = 0;
    int cnt = 0;
    logic [DW-1:0] g = 0;
    calc_done = 0;
    calc_gcd = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
        calc_done = 0;
      end else begin
        calc_done = stray;
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            calc_done = 1;
            calc_gcd = g;
            busy = 0;
          end
        end
        if (calc_start && !job_never) begin
          busy = 1;
          cnt = job_lat;
          g = DW'(gcd_ref(int'(calc_a), int'(calc_b)));
        end
      end
    end
  end
  initial begin
    rsp_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rdy_mode == 2 ? ($urandom % 3 != 0) : rdy_mode == 1;
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (calc_start) starts++;
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          check("rsp_gcd", rsp_gcd, e.g);
          check("rsp_tag", rsp_tag, e.t);
          check("rsp_err", rsp_err, e.e);
          exp_jobs++;
        end
      end
    end
  end
  task automatic send(input int a, input int b, input int tg, input bit nv, input int lat);
    bit acc = 0;
    int n = 0;
    bit er;
    @(posedge clk);
    #1;
    req_valid = 1;
    req_a = DW'(a);
    req_b = DW'(b);
    req_tag = TGW'(tg);
    while (!acc && n < 5000) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 0;
    if (!acc) check("accept_timeout", 0, 1);
    else begin
      job_never = nv;
      job_lat = lat;
      er = nv && a != 0 && b != 0;
      q.push_back('{g: er ? '0 : DW'(gcd_ref(a, b)), t: TGW'(tg), e: er});
      if (er && exp_to < 255) exp_to++;
    end
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int s0, n;
    bit ok;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_calc_start", calc_start, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_timeouts", timeouts, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);
    s0 = starts;
    send(48, 18, 3, 0, 5);
    drain();
    check("basic_starts", starts - s0, 1);
    check("basic_jobs_done", jobs_done, 1);
    s0 = starts;
    send(0, 35, 1, 0, 5);
    @(negedge clk);
    check("bypass_valid", rsp_valid, 1);
    drain();
    send(0, 0, 2, 0, 5);
    @(negedge clk);
    check("bypass00_valid", rsp_valid, 1);
    drain();
    check("bypass_starts", starts - s0, 0);
    send(9, 6, 4, 1, 5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 200);
    check("timeout_latency", n, TO + 2);
    drain();
    check("timeout_count", timeouts, 1);
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    send(12, 8, 7, 0, 3);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      ok &= rsp_valid && rsp_gcd == 4 && rsp_tag == 7 && !req_ready;
      @(negedge clk);
    end
    check("backpressure_hold", ok, 1);
    rdy_mode = 1;
    drain();
    send(100, 75, 5, 0, 20);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    q.delete();
    exp_jobs = 0;
    exp_to = 0;
    @(negedge clk);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_jobs_done", jobs_done, 0);
    check("midrst_timeouts", timeouts, 0);
    repeat (30) @(negedge clk);
    send(100, 75, 6, 0, 5);
    drain();
    s0 = starts;
    @(posedge clk);
    #1;
    stray = 1;
    @(posedge clk);
    #1;
    stray = 0;
    repeat (2) @(negedge clk);
    check("stray_req_ready", req_ready, 1);
    check("stray_rsp_valid", rsp_valid, 0);
    check("stray_starts", starts - s0, 0);
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 255));
      b = ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 255));
      send(a, b, int'($urandom % 16), $urandom % 8 == 0, int'($urandom_range(1, 30)));
    end
    drain();
    check("rand_jobs_done", jobs_done, exp_jobs);
    check("rand_timeouts", timeouts, exp_to);
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) send(3, 5, i % 16, 1, 5);
    drain();
    check("sat_timeouts", timeouts, 255);
    check("sat_timeouts_model", timeouts, exp_to);
    check("sat_jobs_done", jobs_done, exp_jobs);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
